isa_sequencer: RTL and testbench

- Fetch/decode/execute sequencer for the 9-bit ISA datapath: walks the program counter, reads instructions from a synchronous instruction memory, and decodes them.
- Issues the 3-bit ALU command plus register-file controls, then consumes the ALU's jump flag to resolve conditional branches.
- Sits between instruction memory and the register file/ALU; it is the control-side counterpart that drives and listens to the ALU.

---
 rtl/isa_sequencer_if.sv | 24 ++
 rtl/isa_sequencer.sv | 150 +++++++++++++++
 tb/tb_isa_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/isa_sequencer_if.sv
// Sequencer-side bus: instruction memory fetch port plus ALU / register-file control.
// The master modport is the sequencer; the slave modport is the memory/datapath side.
interface isa_sequencer_if #(
    parameter int PC_W = 10
);
    logic [PC_W-1:0] imem_addr_o;
    logic            imem_re_o;
    logic [8:0]      instr_i;
    logic [2:0]      alu_cmd_o;
    logic [2:0]      rd_o;
    logic [2:0]      rs_o;
    logic            reg_we_o;
    logic            flag_i;

    modport master (
        output imem_addr_o, imem_re_o, alu_cmd_o, rd_o, rs_o, reg_we_o,
        input  instr_i, flag_i
    );

    modport slave (
        input  imem_addr_o, imem_re_o, alu_cmd_o, rd_o, rs_o, reg_we_o,
        output instr_i, flag_i
    );
endinterface

// File: rtl/isa_sequencer.sv
// Fetch/decode/execute sequencer for the 9-bit ISA datapath; three cycles per
// instruction, no pipelining, conditional branches resolved from the ALU flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_i after reset
// S_FETCH  | imem read issued at pc
// S_DECODE | instruction word captured into ir
// S_EXEC   | ir decoded, ALU/regfile controls driven, pc updated
// S_HALT   | halt opcode executed; done_o high, start_i restarts
module isa_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [PC_W-1:0]   start_addr_i,
    isa_sequencer_if.master   bus,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_NOP  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;
    localparam logic [2:0] OP_BR   = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [8:0]         ir_q, ir_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic               imem_re;
    logic [2:0]         alu_cmd;
    logic               reg_we;
    logic [2:0]         opcode;
    logic [PC_W-1:0]    br_off;

    assign opcode = ir_q[8:6];
    assign br_off = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            flag_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flag_q    <= flag_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flag_d    = flag_q;
        retired_d = retired_q;
        imem_re   = 1'b0;
        alu_cmd   = 3'b000;
        reg_we    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    pc_d      = start_addr_i;
                    retired_d = '0;
                    flag_d    = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_re = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = bus.instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                retired_d = retired_q + CNT_ONE;
                state_d   = S_FETCH;
                pc_d      = pc_q + PC_ONE;
                case (opcode)
                    OP_ADD, OP_LSL, OP_XOR, OP_SUB: begin
                        alu_cmd = opcode;
                        reg_we  = 1'b1;
                        flag_d  = bus.flag_i;
                    end
                    OP_CMP: begin
                        alu_cmd = OP_CMP;
                        flag_d  = bus.flag_i;
                    end
                    OP_BR: begin
                        // branch tests the flag latched by an earlier ALU/cmp op
                        if (flag_q) pc_d = pc_q + br_off;
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    OP_NOP: begin
                        pc_d = pc_q + PC_ONE;
                    end
                    default: begin
                        pc_d = pc_q + PC_ONE;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_addr_o = pc_q;
    assign bus.imem_re_o   = imem_re;
    assign bus.alu_cmd_o   = alu_cmd;
    assign bus.reg_we_o    = reg_we;
    assign bus.rd_o        = ir_q[5:3];
    assign bus.rs_o        = ir_q[2:0];

    assign busy_o    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign done_o    = (state_q == S_HALT);
    assign retired_o = retired_q;

endmodule

// File: tb/tb_isa_sequencer.sv
// Directed bench for isa_sequencer: small synchronous imem model, hand-computed
// expectations sampled on the falling clock edge.
module tb_isa_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    logic              clk;
    logic              reset_n;
    logic              start_i;
    logic [PC_W-1:0]   start_addr_i;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  retired_o;

    logic [8:0]        imem [0:(1<<PC_W)-1];

    int total;
    int passed;

    isa_sequencer_if #(.PC_W(PC_W)) bus ();

    isa_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .bus          (bus.master),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .retired_o    (retired_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.imem_re_o) bus.instr_i <= imem[bus.imem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge inside FETCH.
    task automatic launch(input logic [PC_W-1:0] addr);
        start_i      = 1'b1;
        start_addr_i = addr;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        reset_n      = 1'b0;
        start_i      = 1'b0;
        start_addr_i = '0;
        bus.flag_i   = 1'b0;
        bus.instr_i  = '0;
        for (int i = 0; i < (1 << PC_W); i++) imem[i] = 9'h080;
        imem[10'h004] = 9'b000_001_010;
        imem[10'h005] = 9'b100_000_000;
        imem[10'h009] = 9'b100_000_000;
        imem[10'h00A] = 9'b111_000_001;
        imem[10'h00B] = 9'b101_111110;
        imem[10'h00C] = 9'b100_000_000;
        imem[10'h3FF] = 9'b010_000_000;
        imem[10'h000] = 9'b100_000_000;
        imem[10'h3EF] = 9'b111_010_011;
        imem[10'h3F0] = 9'b101_011111;
        imem[10'h00F] = 9'b100_000_000;
        imem[10'h020] = 9'b001_011_100;
        imem[10'h021] = 9'b100_000_000;

        #3;
        check("rst_busy",    busy_o, 0);
        check("rst_done",    done_o, 0);
        check("rst_addr",    bus.imem_addr_o, 0);
        check("rst_re",      bus.imem_re_o, 0);
        check("rst_we",      bus.reg_we_o, 0);
        check("rst_alu",     bus.alu_cmd_o, 0);
        check("rst_retired", retired_o, 0);

        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy_o, 0);

        // add r1,r2 then halt
        launch(10'h004);
        check("t1_fetch_re",   bus.imem_re_o, 1);
        check("t1_fetch_addr", bus.imem_addr_o, 10'h004);
        check("t1_fetch_busy", busy_o, 1);
        cyc(1);
        check("t1_dec_re", bus.imem_re_o, 0);
        check("t1_dec_we", bus.reg_we_o, 0);
        cyc(1);
        check("t1_exec_alu", bus.alu_cmd_o, 3'b000);
        check("t1_exec_rd",  bus.rd_o, 1);
        check("t1_exec_rs",  bus.rs_o, 2);
        check("t1_exec_we",  bus.reg_we_o, 1);
        cyc(1);
        check("t1_we_pulse", bus.reg_we_o, 0);
        check("t1_addr2",    bus.imem_addr_o, 10'h005);
        check("t1_ret1",     retired_o, 1);
        cyc(2);
        check("t1_halt_we", bus.reg_we_o, 0);
        cyc(1);
        check("t1_done",    done_o, 1);
        check("t1_busy",    busy_o, 0);
        check("t1_retired", retired_o, 2);
        check("t1_pc_held", bus.imem_addr_o, 10'h005);

        // cmp with flag=1, branch -2 taken
        bus.flag_i = 1'b1;
        launch(10'h00A);
        check("t2_done_drop", done_o, 0);
        check("t2_ret_clear", retired_o, 0);
        check("t2_addr",      bus.imem_addr_o, 10'h00A);
        cyc(2);
        check("t2_cmp_alu", bus.alu_cmd_o, 3'b111);
        check("t2_cmp_we",  bus.reg_we_o, 0);
        cyc(3);
        check("t2_br_alu", bus.alu_cmd_o, 3'b000);
        check("t2_br_we",  bus.reg_we_o, 0);
        cyc(1);
        check("t2_br_taken", bus.imem_addr_o, 10'h009);
        cyc(3);
        check("t2_done",    done_o, 1);
        check("t2_retired", retired_o, 3);

        // same program, flag=0: branch falls through
        bus.flag_i = 1'b0;
        launch(10'h00A);
        cyc(2);
        check("t3_cmp_we", bus.reg_we_o, 0);
        cyc(3);
        check("t3_br_we", bus.reg_we_o, 0);
        cyc(1);
        check("t3_br_not_taken", bus.imem_addr_o, 10'h00C);
        cyc(3);
        check("t3_done", done_o, 1);

        // pc increment wraps at the top of the address space
        launch(10'h3FF);
        cyc(3);
        check("t4_wrap_addr", bus.imem_addr_o, 10'h000);
        cyc(3);
        check("t4_done",    done_o, 1);
        check("t4_retired", retired_o, 2);

        // branch +31 from 0x3F0 wraps to 0x00F
        bus.flag_i = 1'b1;
        launch(10'h3EF);
        cyc(3);
        check("t5_br_fetch", bus.imem_addr_o, 10'h3F0);
        cyc(3);
        check("t5_br_wrap", bus.imem_addr_o, 10'h00F);
        cyc(3);
        check("t5_done", done_o, 1);
        bus.flag_i = 1'b0;

        // restart from HALT at 0x020, start_i held while busy, reset during EXEC
        launch(10'h020);
        check("t6_done_drop", done_o, 0);
        check("t6_ret_clear", retired_o, 0);
        check("t6_addr",      bus.imem_addr_o, 10'h020);
        start_i      = 1'b1;
        start_addr_i = 10'h100;
        cyc(2);
        check("t6_exec_we",   bus.reg_we_o, 1);
        check("t6_exec_alu",  bus.alu_cmd_o, 3'b001);
        check("t6_exec_rd",   bus.rd_o, 3);
        check("t6_exec_rs",   bus.rs_o, 4);
        check("t6_start_ign", bus.imem_addr_o, 10'h020);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_we",      bus.reg_we_o, 0);
        check("t6_rst_busy",    busy_o, 0);
        check("t6_rst_addr",    bus.imem_addr_o, 0);
        check("t6_rst_retired", retired_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1);
        check("t6_idle_busy", busy_o, 0);
        check("t6_idle_done", done_o, 0);

        launch(10'h020);
        cyc(6);
        check("t7_done",    done_o, 1);
        check("t7_retired", retired_o, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
